hdx_pad_ctrl: RTL and testbench



---
 rtl/hdx_pkg.sv | 31 +++
 rtl/hdx_sync2.sv | 21 ++
 rtl/hdx_pad_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hdx_pad_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdx_pkg.sv
// rtl/hdx_pkg.sv - shared state type, default timing constants and sizing helpers for hdx_pad_ctrl
package hdx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TXB,
        TURN_W,
        TURN_R,
        RXB,
        DONE
    } hdx_state_e;

    localparam int DEF_BIT_CYCLES = 8;
    localparam int SAMPLE_PT      = DEF_BIT_CYCLES / 2 - 1;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int sample_pt(input int bit_cycles);
        return bit_cycles / 2 - 1;
    endfunction

endpackage

// File: rtl/hdx_sync2.sv
// rtl/hdx_sync2.sv - two-flop synchronizer for the pad readback, resets to the idle-high level
module hdx_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdx_pad_ctrl.sv
// rtl/hdx_pad_ctrl.sv - half-duplex single-wire pad controller; even parity bit enabled by HDX_PARITY_EN
module hdx_pad_ctrl #(
    parameter int BIT_CYCLES  = 8,
    parameter int TURN_CYCLES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              PAD_I,
    output logic              PAD_T,
    input  logic              PAD_O
);

    import hdx_pkg::*;

`ifdef HDX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    // Serial frame width: data bits plus the optional parity bit.
    localparam int SW     = DATA_W + PB;
    localparam int CW     = clog2((BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES);
    localparam int BW     = clog2(SW);
    localparam int SMP_PT = sample_pt(BIT_CYCLES);

    localparam logic [CW-1:0] BC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] TC_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] SMP_AT  = CW'(SMP_PT);
    localparam logic [BW-1:0] BI_LAST = BW'(SW - 1);

    hdx_state_e    state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic          wr_q;
    logic [SW-1:0] tx_sh;
    logic [SW-1:0] rx_sh;
    logic          pad_t_q;
    logic          pad_i_q;
    logic          pad_s;
`ifdef HDX_PARITY_EN
    logic          err_q;
`endif

    hdx_sync2 u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (PAD_O),
        .q     (pad_s)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign PAD_T     = pad_t_q;
    assign PAD_I     = pad_i_q;
`ifdef HDX_PARITY_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    // Pad outputs are updated together with the state so each state's
    // drive level appears on the first clock spent in that state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            wr_q      <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            pad_t_q   <= 1'b1;
            pad_i_q   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef HDX_PARITY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    pad_t_q <= 1'b1;
                    pad_i_q <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (cmd_valid) begin
                        state   <= START;
                        wr_q    <= cmd_wr;
`ifdef HDX_PARITY_EN
                        tx_sh   <= {^cmd_data, cmd_data};
`else
                        tx_sh   <= cmd_data;
`endif
                        pad_t_q <= 1'b0;
                        pad_i_q <= 1'b0;
                    end
                end

                START: begin
                    if (cnt == BC_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (wr_q) begin
                            state   <= TXB;
                            pad_i_q <= tx_sh[0];
                        end else begin
                            state   <= TURN_R;
                            pad_t_q <= 1'b1;
                            pad_i_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                TXB: begin
                    if (cnt == BC_LAST) begin
                        cnt <= '0;
                        if (bit_idx == BI_LAST) begin
                            state   <= TURN_W;
                            pad_t_q <= 1'b1;
                            pad_i_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_sh   <= {1'b0, tx_sh[SW-1:1]};
                            pad_i_q <= tx_sh[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                TURN_W: begin
                    if (cnt == TC_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                TURN_R: begin
                    if (cnt == TC_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= RXB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RXB: begin
                    // Mid-bit sample, shifted in from the top so the first
                    // received bit ends up at bit 0 after SW samples.
                    if (cnt == SMP_AT) begin
                        rx_sh <= {pad_s, rx_sh[SW-1:1]};
                    end
                    if (cnt == BC_LAST) begin
                        cnt <= '0;
                        if (bit_idx == BI_LAST) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rx_sh[DATA_W-1:0];
`ifdef HDX_PARITY_EN
                            err_q     <= ^rx_sh;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    pad_t_q <= 1'b1;
                    pad_i_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdx_pad_ctrl.sv
// tb/tb_hdx_pad_ctrl.sv - directed self-checking bench for hdx_pad_ctrl
module tb_hdx_pad_ctrl;

    localparam int BC = 8;
    localparam int TC = 2;
    localparam int DW = 8;
`ifdef HDX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB     = DW + PB;
    localparam int W_DRV  = (1 + NB) * BC;
    localparam int W_LAT  = W_DRV + TC;
    localparam int R_DAT0 = BC + TC;
    localparam int R_LAT  = BC + TC + NB * BC + 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          PAD_I;
    logic          PAD_T;
    logic          PAD_O;

    int checks = 0;
    int errors = 0;

    hdx_pad_ctrl #(
        .BIT_CYCLES  (BC),
        .TURN_CYCLES (TC),
        .DATA_W      (DW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PAD_I     (PAD_I),
        .PAD_T     (PAD_T),
        .PAD_O     (PAD_O)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic wr, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called one step after the acceptance edge; k counts clocks from it.
    task automatic run_write(input logic [DW-1:0] d);
        logic [DW:0] txb;
        logic        exp_t;
        logic        exp_i;
        logic        exp_r;
        txb = {^d, d};
        for (int k = 0; k <= W_LAT; k++) begin
            exp_t = (k < W_DRV) ? 1'b0 : 1'b1;
            exp_i = (k < BC) ? 1'b0 : (k < W_DRV) ? txb[(k - BC) / BC] : 1'b1;
            exp_r = (k == W_LAT);
            checks++;
            if (PAD_T !== exp_t) begin
                errors++;
                $display("FAIL wr_pad_t k=%0d data=%0h: got %b expected %b", k, d, PAD_T, exp_t);
            end
            checks++;
            if (PAD_I !== exp_i) begin
                errors++;
                $display("FAIL wr_pad_i k=%0d data=%0h: got %b expected %b", k, d, PAD_I, exp_i);
            end
            checks++;
            if (cmd_ready !== exp_r || busy !== !exp_r) begin
                errors++;
                $display("FAIL wr_ready k=%0d: got ready=%b busy=%b expected ready=%b", k, cmd_ready, busy, exp_r);
            end
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_rsp_valid k=%0d: got %b expected 0", k, rsp_valid);
            end
            if (k < W_LAT) tick();
        end
    endtask

    task automatic run_read(input logic [DW-1:0] d, input logic pbit);
        logic [DW:0] rxb;
        logic        exp_err;
        logic        exp_t;
        rxb     = {pbit, d};
        exp_err = (PB != 0) ? (^d ^ pbit) : 1'b0;
        for (int k = 0; k <= R_LAT; k++) begin
            PAD_O = (k >= R_DAT0 && k < R_DAT0 + NB * BC) ? rxb[(k - R_DAT0) / BC] : 1'b1;
            exp_t = (k < BC) ? 1'b0 : 1'b1;
            checks++;
            if (PAD_T !== exp_t) begin
                errors++;
                $display("FAIL rd_pad_t k=%0d: got %b expected %b", k, PAD_T, exp_t);
            end
            if (k < BC) begin
                checks++;
                if (PAD_I !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_start_bit k=%0d: got %b expected 0", k, PAD_I);
                end
            end
            checks++;
            if (rsp_valid !== (k == R_LAT - 1)) begin
                errors++;
                $display("FAIL rd_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, (k == R_LAT - 1));
            end
            if (k >= R_LAT - 1) begin
                checks++;
                if (rsp_data !== d) begin
                    errors++;
                    $display("FAIL rd_rsp_data k=%0d: got %0h expected %0h", k, rsp_data, d);
                end
            end
            if (k == R_LAT - 1) begin
                checks++;
                if (rsp_err !== exp_err) begin
                    errors++;
                    $display("FAIL rd_rsp_err: got %b expected %b", rsp_err, exp_err);
                end
            end
            checks++;
            if (cmd_ready !== (k == R_LAT)) begin
                errors++;
                $display("FAIL rd_ready k=%0d: got %b expected %b", k, cmd_ready, (k == R_LAT));
            end
            if (k < R_LAT) tick();
        end
        PAD_O = 1'b1;
    endtask

    task automatic test_reset;
        RST_N     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_data  = '0;
        PAD_O     = 1'b1;
        repeat (3) tick();
        checks++;
        if (PAD_T !== 1'b1 || PAD_I !== 1'b1) begin
            errors++;
            $display("FAIL reset_pad: got T=%b I=%b expected T=1 I=1", PAD_T, PAD_I);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b d=%0h e=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || PAD_T !== 1'b1 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_quiet i=%0d: got v=%b T=%b ready=%b expected 0/1/1", i, rsp_valid, PAD_T, cmd_ready);
            end
        end
    endtask

    task automatic test_write(input logic [DW-1:0] d);
        accept(1'b1, d);
        run_write(d);
    endtask

    task automatic test_read(input logic [DW-1:0] d, input logic pbit);
        accept(1'b0, 8'h00);
        run_read(d, pbit);
    endtask

    task automatic test_reset_mid_write;
        accept(1'b1, 8'hC3);
        repeat (43) tick();
        checks++;
        if (PAD_T !== 1'b0 || PAD_I !== 1'b0) begin
            errors++;
            $display("FAIL midwr_before: got T=%b I=%b expected T=0 I=0", PAD_T, PAD_I);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (PAD_T !== 1'b1 || PAD_I !== 1'b1) begin
            errors++;
            $display("FAIL midwr_async_pad: got T=%b I=%b expected T=1 I=1", PAD_T, PAD_I);
        end
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midwr_async_state: got ready=%b v=%b expected 1/0", cmd_ready, rsp_valid);
        end
        tick();
        RST_N = 1'b1;
        tick();
        test_write(8'h3C);
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_data  = 8'h96;
        tick();
        cmd_wr    = 1'b0;
        cmd_data  = 8'hFF;
        run_write(8'h96);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || PAD_T !== 1'b0 || PAD_I !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%b T=%b I=%b expected 0/0/0", cmd_ready, PAD_T, PAD_I);
        end
        run_read(8'h81, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write(8'hA5);
        test_read(8'h3C, 1'b0);
        test_reset_mid_write();
        test_back_to_back();
`ifdef HDX_PARITY_EN
        test_write(8'h07);
        test_read(8'h3C, 1'b1);
        test_read(8'h5B, 1'b1);
`else
        test_read(8'h5B, 1'b0);
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
